// File: rtl/spram_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : spram_arbiter
// Purpose  : Round-robin arbiter that lets two requesters share one
//            single-port RAM, returning read data in acceptance order.
// Revision : 1.0 - initial release
// =====================================================================
module spram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // One tag stage for the request register plus one per RAM read cycle.
  localparam int c_TAG_DEPTH = RD_LATENCY + 1;

  logic                   r_last_b;
  logic [c_TAG_DEPTH-1:0] r_tag_vld;
  logic [c_TAG_DEPTH-1:0] r_tag_b;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_accept;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // A wins a contended cycle only if B was the last one served.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!tb_rst) begin
      if (a_valid && (!b_valid || r_last_b)) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign w_accept = w_grant_a | w_grant_b;

  always_comb begin
    w_sel_we    = a_we;
    w_sel_addr  = a_addr;
    w_sel_wdata = a_wdata;
    if (w_grant_b) begin
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_last_b    <= 1'b1;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_en   <= 1'b0;
      r_tag_vld   <= '0;
      r_tag_b     <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      r_tag_vld <= {r_tag_vld[c_TAG_DEPTH-2:0], w_accept & ~w_sel_we};
      r_tag_b   <= {r_tag_b[c_TAG_DEPTH-2:0], w_grant_b};
      if (w_accept) begin
        ram_addr    <= w_sel_addr;
        ram_wr_data <= w_sel_wdata;
        ram_wr_en   <= w_sel_we;
        r_last_b    <= w_grant_b;
      end
    end
  end

  assign a_rvalid = r_tag_vld[c_TAG_DEPTH-1] & ~r_tag_b[c_TAG_DEPTH-1];
  assign b_rvalid = r_tag_vld[c_TAG_DEPTH-1] &  r_tag_b[c_TAG_DEPTH-1];
  assign rdata    = ram_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_spram_arbiter.sv
`default_nettype none
// Bench for spram_arbiter: one instance per legal read latency share the same
// stimulus; a cycle-level reference predicts grants, RAM port and responses.
module tb_spram_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;

  logic a_valid, b_valid, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic a_ready1, b_ready1, a_rvalid1, b_rvalid1, ram_wr_en1;
  logic a_ready2, b_ready2, a_rvalid2, b_rvalid2, ram_wr_en2;
  logic [DW-1:0] rdata1, ram_wr_data1, ram_rd_data1, rdata2, ram_wr_data2, ram_rd_data2;
  logic [AW-1:0] ram_addr1, ram_addr2;

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .tb_rst(tb_rst),
    .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid1),
    .b_valid(b_valid), .b_ready(b_ready1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid1), .rdata(rdata1),
    .ram_addr(ram_addr1), .ram_wr_data(ram_wr_data1), .ram_wr_en(ram_wr_en1),
    .ram_rd_data(ram_rd_data1)
  );

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .tb_rst(tb_rst),
    .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid2),
    .b_valid(b_valid), .b_ready(b_ready2), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid2), .rdata(rdata2),
    .ram_addr(ram_addr2), .ram_wr_data(ram_wr_data2), .ram_wr_en(ram_wr_en2),
    .ram_rd_data(ram_rd_data2)
  );

  // Single-port RAMs: latency 1 (no output register) and latency 2 (output register).
  logic [DW-1:0] mem1 [0:31];
  logic [DW-1:0] mem2 [0:31];
  logic [DW-1:0] rd2_q;
  always @(posedge clk) begin
    if (ram_wr_en1) mem1[ram_addr1] <= ram_wr_data1;
    ram_rd_data1 <= mem1[ram_addr1];
    if (ram_wr_en2) mem2[ram_addr2] <= ram_wr_data2;
    rd2_q        <= mem2[ram_addr2];
    ram_rd_data2 <= rd2_q;
  end

  // Reference state
  int            cyc;
  logic          last_b;
  logic [DW-1:0] ref_mem [0:31];
  logic          ring_v [8];
  logic          ring_b [8];
  logic [DW-1:0] ring_d [8];
  int            ring_c [8];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          exp_we;
  int            passed, total, a_rv_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_lat(input int lat, input string sfx, input logic wr_en,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic arv, input logic brv, input logic [DW-1:0] rd);
    int   idx;
    logic ev;
    idx = (cyc - lat) % 8;
    ev  = ring_v[idx] && (ring_c[idx] == cyc - lat);
    chk({"ram_wr_en_", sfx}, wr_en, exp_we);
    chk({"ram_addr_", sfx}, addr, exp_addr);
    if (exp_we) chk({"ram_wr_data_", sfx}, wd, exp_wdata);
    chk({"a_rvalid_", sfx}, arv, ev && !ring_b[idx]);
    chk({"b_rvalid_", sfx}, brv, ev && ring_b[idx]);
    if (ev) chk({"rdata_", sfx}, rd, ring_d[idx]);
  endtask

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic step(output logic ga, output logic gb);
    #1;
    ga = a_valid && (!b_valid || last_b);
    gb = b_valid && !ga;
    chk("a_ready_L1", a_ready1, ga);
    chk("b_ready_L1", b_ready1, gb);
    chk("a_ready_L2", a_ready2, ga);
    chk("b_ready_L2", b_ready2, gb);
    @(posedge clk);
    #1;
    cyc++;
    exp_we = 1'b0;
    ring_v[cyc % 8] = 1'b0;
    if (ga || gb) begin
      last_b   = gb;
      exp_addr = ga ? a_addr : b_addr;
      if (ga ? a_we : b_we) begin
        exp_we            = 1'b1;
        exp_wdata         = ga ? a_wdata : b_wdata;
        ref_mem[exp_addr] = exp_wdata;
      end else begin
        ring_v[cyc % 8] = 1'b1;
        ring_b[cyc % 8] = gb;
        ring_d[cyc % 8] = ref_mem[exp_addr];
        ring_c[cyc % 8] = cyc;
      end
    end
    chk_lat(1, "L1", ram_wr_en1, ram_addr1, ram_wr_data1, a_rvalid1, b_rvalid1, rdata1);
    chk_lat(2, "L2", ram_wr_en2, ram_addr2, ram_wr_data2, a_rvalid2, b_rvalid2, rdata2);
    a_rv_count += int'(a_rvalid1);
    @(negedge clk);
  endtask

  task automatic req(input logic is_b, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] d);
    logic ga, gb;
    a_valid = !is_b; a_we = we; a_addr = addr; a_wdata = d;
    b_valid = is_b;  b_we = we; b_addr = addr; b_wdata = d;
    step(ga, gb);
    chk("single_grant", is_b ? gb : ga, 1'b1);
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) step(ga, gb);
  endtask

  task automatic chk_all_zero(input string sfx, input logic ar, input logic br, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic arv, input logic brv);
    chk({"rst_a_ready_", sfx}, ar, 1'b0);
    chk({"rst_b_ready_", sfx}, br, 1'b0);
    chk({"rst_wr_en_", sfx}, we, 1'b0);
    chk({"rst_addr_", sfx}, addr, '0);
    chk({"rst_wr_data_", sfx}, wd, '0);
    chk({"rst_a_rvalid_", sfx}, arv, 1'b0);
    chk({"rst_b_rvalid_", sfx}, brv, 1'b0);
  endtask

  // Asserts reset mid-cycle with both valids high; checks outputs clear at once.
  task automatic do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    tb_rst  = 1'b1;
    #1;
    chk_all_zero("L1", a_ready1, b_ready1, ram_wr_en1, ram_addr1, ram_wr_data1, a_rvalid1, b_rvalid1);
    chk_all_zero("L2", a_ready2, b_ready2, ram_wr_en2, ram_addr2, ram_wr_data2, a_rvalid2, b_rvalid2);
    @(posedge clk);
    @(negedge clk);
    tb_rst    = 1'b0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    last_b    = 1'b1;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_we    = 1'b0;
    for (int i = 0; i < 8; i++) ring_v[i] = 1'b0;
  endtask

  initial begin
    logic ga, gb;
    logic hold_a, hold_b;
    int   grants_a, grants_b;
    passed = 0; total = 0; a_rv_count = 0; cyc = 10;
    a_valid = 1'b0; b_valid = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    tb_rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Write 0x5A to address 3 from A, then read it back.
    req(1'b0, 1'b1, 5'd3, 8'h5A);
    req(1'b0, 1'b0, 5'd3, 8'h00);
    idle(4);

    // Fill every address from B, then stream reads from A.
    for (int i = 0; i < 32; i++) req(1'b1, 1'b1, AW'(i), DW'(8'hFF - i));
    a_rv_count = 0;
    for (int i = 0; i < 32; i++) req(1'b0, 1'b0, AW'(i), 8'h00);
    idle(4);
    chk("a_rvalid_pulses_L1", a_rv_count, 32);

    // Continuous contention right after reset: strict alternation starting with A.
    do_reset();
    grants_a = 0; grants_b = 0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd5;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd9;
    for (int i = 0; i < 8; i++) begin
      step(ga, gb);
      chk("alternate_grant", {ga, gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
      grants_a += int'(ga);
      grants_b += int'(gb);
    end
    chk("contended_grants_a", grants_a, 4);
    chk("contended_grants_b", grants_b, 4);
    idle(4);

    // A writes address 7, B reads it on the very next cycle.
    req(1'b0, 1'b1, 5'd7, 8'h11);
    req(1'b1, 1'b0, 5'd7, 8'h00);
    idle(4);

    // Reset with three reads in flight; none may complete afterwards.
    req(1'b0, 1'b0, 5'd1, 8'h00);
    req(1'b0, 1'b0, 5'd2, 8'h00);
    req(1'b0, 1'b0, 5'd3, 8'h00);
    do_reset();
    idle(5);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd4;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd6;
    step(ga, gb);
    chk("post_reset_first_grant_a", ga, 1'b1);
    idle(4);

    // Random traffic; a requester that was not served keeps its request.
    hold_a = 1'b0; hold_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold_a) begin
        a_valid = 1'($urandom_range(0, 1));
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = AW'($urandom);
        a_wdata = DW'($urandom);
      end
      if (!hold_b) begin
        b_valid = 1'($urandom_range(0, 1));
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = AW'($urandom);
        b_wdata = DW'($urandom);
      end
      step(ga, gb);
      hold_a = a_valid && !ga;
      hold_b = b_valid && !gb;
    end
    idle(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
